// File: rtl/bb8051_seq_decoder_pkg.sv
// -----------------------------------------------------------------------------
// bb8051_seq_decoder_pkg
//   Shared definitions for the multi-cycle 8051 sequential decoder:
//   ALU operation codes, operand source/destination select codes, PC action
//   codes, the opcode constants that the decoder recognises, the decoder state
//   encoding, and the records passed between the opcode table and the top.
// -----------------------------------------------------------------------------
package bb8051_seq_decoder_pkg;

  // ALU operation presented on alu_op_code
  typedef enum logic [3:0] {
    ALU_NOP  = 4'd0,
    ALU_ADD  = 4'd1,
    ALU_ADDC = 4'd2,
    ALU_MOV  = 4'd3
  } alu_op_e;

  // Operand source / destination selects (src1_sel, src2_sel, dst_sel)
  typedef enum logic [2:0] {
    SEL_NONE   = 3'd0,
    SEL_ACC    = 3'd1,
    SEL_RN     = 3'd2,
    SEL_IND    = 3'd3,
    SEL_DIRECT = 3'd4,
    SEL_IMM    = 3'd5
  } sel_e;

  // PC action presented on pc_act; 2'b1x is reserved
  typedef enum logic [1:0] {
    PC_SEQ  = 2'b00,
    PC_JUMP = 2'b01
  } pc_act_e;

  // Decoder control states
  typedef enum logic [2:0] {
    ST_FETCH1 = 3'd0,
    ST_FETCH2 = 3'd1,
    ST_FETCH3 = 3'd2,
    ST_ISSUE  = 3'd3,
    ST_TRAP   = 3'd4
  } state_e;

  // Opcode constants
  localparam logic [7:0] OPC_NOP       = 8'h00;
  localparam logic [7:0] OPC_LJMP      = 8'h02;
  localparam logic [7:0] OPC_ADD_IMM   = 8'h24;
  localparam logic [7:0] OPC_ADD_DIR   = 8'h25;
  localparam logic [7:0] OPC_ADD_IND   = 8'h26;  // 26/27, Ri in bit 0
  localparam logic [7:0] OPC_ADD_RN    = 8'h28;  // 28..2F, Rn in bits 2:0
  localparam logic [7:0] OPC_ADDC_IMM  = 8'h34;
  localparam logic [7:0] OPC_ADDC_DIR  = 8'h35;
  localparam logic [7:0] OPC_ADDC_IND  = 8'h36;  // 36/37
  localparam logic [7:0] OPC_ADDC_RN   = 8'h38;  // 38..3F
  localparam logic [7:0] OPC_MOV_DIR_IMM = 8'h75;

  // Instruction lengths as returned by the opcode table
  localparam logic [1:0] LEN_1 = 2'd1;
  localparam logic [1:0] LEN_2 = 2'd2;
  localparam logic [1:0] LEN_3 = 2'd3;

  // Result of one opcode-table lookup for a given micro-op index
  typedef struct packed {
    logic [1:0] len;       // instruction length in bytes (1..3)
    logic       two_uops;  // instruction issues two micro-ops
    logic       illegal;   // opcode not recognised
    alu_op_e    alu_op;
    sel_e       src1;
    sel_e       src2;
    sel_e       dst;
    pc_act_e    pc_act;
    logic       uop_last;  // this micro-op index completes the instruction
  } uop_decode_t;

  // Registered micro-op output stage
  typedef struct packed {
    alu_op_e    alu_op;
    sel_e       src1;
    sel_e       src2;
    sel_e       dst;
    logic [7:0] op1;
    logic [7:0] op2;
    logic [7:0] op3;
    logic       last;
    pc_act_e    pc_act;
  } uop_out_t;

  localparam uop_out_t UOP_OUT_IDLE = '0;

  // Rn-form opcodes share their upper five bits (register index in [2:0])
  function automatic logic is_rn_form(input logic [7:0] opc, input logic [7:0] base);
    return opc[7:3] == base[7:3];
  endfunction

  // @Ri-form opcodes share their upper seven bits (register index in [0])
  function automatic logic is_ind_form(input logic [7:0] opc, input logic [7:0] base);
    return opc[7:1] == base[7:1];
  endfunction

endpackage

// File: rtl/bb8051_seq_decoder_op_table.sv
// -----------------------------------------------------------------------------
// bb8051_seq_decoder_op_table
//   Purely combinational opcode table. Given an opcode byte and the index of
//   the micro-op about to be issued, returns instruction length, micro-op
//   count, illegal flag and the fields of that micro-op.
// Ports
//   opcode_i   in   8   opcode byte to look up
//   uop_idx_i  in   1   micro-op index (0 = first, 1 = second)
//   dec_o      out  -   uop_decode_t lookup result
// Unknown opcodes return illegal=1 with a 1-byte NOP body, so the top can
// either trap or simply issue the NOP.
// -----------------------------------------------------------------------------
module bb8051_seq_decoder_op_table
  import bb8051_seq_decoder_pkg::*;
(
  input  logic [7:0]  opcode_i,
  input  logic        uop_idx_i,
  output uop_decode_t dec_o
);

  alu_op_e arith_op;

  // Bit 4 distinguishes the ADDC row (3x) from the ADD row (2x)
  assign arith_op = opcode_i[4] ? ALU_ADDC : ALU_ADD;

  always_comb begin
    dec_o          = '0;
    dec_o.len      = LEN_1;
    dec_o.two_uops = 1'b0;
    dec_o.illegal  = 1'b0;
    dec_o.alu_op   = ALU_NOP;
    dec_o.src1     = SEL_NONE;
    dec_o.src2     = SEL_NONE;
    dec_o.dst      = SEL_NONE;
    dec_o.pc_act   = PC_SEQ;
    dec_o.uop_last = 1'b1;

    if (is_rn_form(opcode_i, OPC_ADD_RN) || is_rn_form(opcode_i, OPC_ADDC_RN)) begin
      dec_o.alu_op = arith_op;
      dec_o.src1   = SEL_ACC;
      dec_o.src2   = SEL_RN;
      dec_o.dst    = SEL_ACC;
    end else if (is_ind_form(opcode_i, OPC_ADD_IND) ||
                 is_ind_form(opcode_i, OPC_ADDC_IND)) begin
      // First micro-op reads Ri to form the address, second does the add.
      dec_o.two_uops = 1'b1;
      if (!uop_idx_i) begin
        dec_o.src1     = SEL_RN;
        dec_o.uop_last = 1'b0;
      end else begin
        dec_o.alu_op = arith_op;
        dec_o.src1   = SEL_ACC;
        dec_o.src2   = SEL_IND;
        dec_o.dst    = SEL_ACC;
      end
    end else begin
      case (opcode_i)
        OPC_ADD_IMM, OPC_ADDC_IMM: begin
          dec_o.len    = LEN_2;
          dec_o.alu_op = arith_op;
          dec_o.src1   = SEL_ACC;
          dec_o.src2   = SEL_IMM;
          dec_o.dst    = SEL_ACC;
        end
        OPC_ADD_DIR, OPC_ADDC_DIR: begin
          dec_o.len    = LEN_2;
          dec_o.alu_op = arith_op;
          dec_o.src1   = SEL_ACC;
          dec_o.src2   = SEL_DIRECT;
          dec_o.dst    = SEL_ACC;
        end
        OPC_MOV_DIR_IMM: begin
          dec_o.len    = LEN_3;
          dec_o.alu_op = ALU_MOV;
          dec_o.src2   = SEL_IMM;
          dec_o.dst    = SEL_DIRECT;
        end
        OPC_LJMP: begin
          dec_o.len    = LEN_3;
          dec_o.pc_act = PC_JUMP;
        end
        OPC_NOP: begin
          dec_o.len = LEN_1;
        end
        default: begin
          dec_o.illegal = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/bb8051_seq_decoder.sv
// -----------------------------------------------------------------------------
// bb8051_seq_decoder
//   Multi-cycle 8051 instruction decoder. Assembles 1-3 byte instructions from
//   the fetch byte stream and issues 1-2 registered micro-ops per instruction
//   over a valid/ready handshake. Supports flush on PC redirect and an
//   illegal-opcode trap.
// Parameters
//   ALU_OP_W      width of alu_op_code
//   SEL_W         width of src1_sel/src2_sel/dst_sel
//   ILLEGAL_TRAP  1: unknown opcode -> TRAP until flush/rst; 0: 1-byte NOP
// Ports
//   clk, rst              clock, synchronous active-high reset
//   flush                 drop partial/in-flight instruction, back to FETCH1
//   byte_valid/byte_in    fetch byte stream; byte_ready = decoder takes it
//   uop_valid/uop_ready   micro-op handshake to the datapath
//   alu_op_code, src1_sel, src2_sel, dst_sel, op1_out..op3_out, uop_last,
//   pc_act                micro-op fields (registered)
//   illegal               high while trapped
//   decoder_wait          high whenever not in FETCH1
// -----------------------------------------------------------------------------
module bb8051_seq_decoder
  import bb8051_seq_decoder_pkg::*;
#(
  parameter int ALU_OP_W     = 4,
  parameter int SEL_W        = 3,
  parameter bit ILLEGAL_TRAP = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                byte_valid,
  input  logic [7:0]          byte_in,
  output logic                byte_ready,
  output logic                uop_valid,
  input  logic                uop_ready,
  output logic [ALU_OP_W-1:0] alu_op_code,
  output logic [SEL_W-1:0]    src1_sel,
  output logic [SEL_W-1:0]    src2_sel,
  output logic [SEL_W-1:0]    dst_sel,
  output logic [7:0]          op1_out,
  output logic [7:0]          op2_out,
  output logic [7:0]          op3_out,
  output logic                uop_last,
  output logic [1:0]          pc_act,
  output logic                illegal,
  output logic                decoder_wait
);

  state_e      state_q, state_d;
  logic [7:0]  op1_q, op1_d;         // opcode captured in FETCH1
  logic [7:0]  op2_q, op2_d;         // first operand captured in FETCH2
  logic        uop_cnt_q, uop_cnt_d; // index of the micro-op on the outputs
  logic        uop_valid_q, uop_valid_d;
  uop_out_t    out_q, out_d;

  logic        in_fetch;
  logic        byte_take;
  logic        uop_hs;
  logic [7:0]  tbl_opcode;
  logic        tbl_uop_idx;
  uop_decode_t dec;

  // ---------------------------------------------------------------------------
  // Opcode lookup. In FETCH1 the opcode is still on byte_in; afterwards it is
  // held in op1_q. While issuing, the table is asked for the *next* micro-op so
  // its fields can be registered on the current handshake.
  // ---------------------------------------------------------------------------
  assign tbl_opcode  = (state_q == ST_FETCH1) ? byte_in : op1_q;
  assign tbl_uop_idx = (state_q == ST_ISSUE) ? (uop_cnt_q + 1'b1) : 1'b0;

  bb8051_seq_decoder_op_table u_op_table (
    .opcode_i  (tbl_opcode),
    .uop_idx_i (tbl_uop_idx),
    .dec_o     (dec)
  );

  assign in_fetch   = (state_q == ST_FETCH1) || (state_q == ST_FETCH2) ||
                      (state_q == ST_FETCH3);
  // Bytes are never taken while reset or flush is asserted
  assign byte_ready = in_fetch && !rst && !flush;
  assign byte_take  = byte_valid && byte_ready;
  assign uop_hs     = uop_valid_q && uop_ready;

  function automatic uop_out_t build_uop(input uop_decode_t d,
                                         input logic [7:0]  b1,
                                         input logic [7:0]  b2,
                                         input logic [7:0]  b3);
    uop_out_t u;
    u        = UOP_OUT_IDLE;
    u.alu_op = d.alu_op;
    u.src1   = d.src1;
    u.src2   = d.src2;
    u.dst    = d.dst;
    u.op1    = b1;
    u.op2    = b2;
    u.op3    = b3;
    u.last   = d.uop_last;
    u.pc_act = d.pc_act;
    return u;
  endfunction

  // ---------------------------------------------------------------------------
  // Next-state and output-stage logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    uop_cnt_d   = uop_cnt_q;
    uop_valid_d = uop_valid_q;
    out_d       = out_q;

    case (state_q)
      ST_FETCH1: begin
        if (byte_take) begin
          op1_d = byte_in;
          if (dec.illegal && ILLEGAL_TRAP) begin
            state_d = ST_TRAP;
          end else if (dec.len == LEN_1) begin
            out_d       = build_uop(dec, byte_in, 8'h00, 8'h00);
            uop_valid_d = 1'b1;
            uop_cnt_d   = 1'b0;
            state_d     = ST_ISSUE;
          end else begin
            state_d = ST_FETCH2;
          end
        end
      end

      ST_FETCH2: begin
        if (byte_take) begin
          op2_d = byte_in;
          if (dec.len == LEN_2) begin
            out_d       = build_uop(dec, op1_q, byte_in, 8'h00);
            uop_valid_d = 1'b1;
            uop_cnt_d   = 1'b0;
            state_d     = ST_ISSUE;
          end else begin
            state_d = ST_FETCH3;
          end
        end
      end

      ST_FETCH3: begin
        if (byte_take) begin
          out_d       = build_uop(dec, op1_q, op2_q, byte_in);
          uop_valid_d = 1'b1;
          uop_cnt_d   = 1'b0;
          state_d     = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        // Outputs hold while the datapath stalls; they change only on handshake.
        if (uop_hs) begin
          if (out_q.last || !dec.two_uops) begin
            out_d       = UOP_OUT_IDLE;
            uop_valid_d = 1'b0;
            uop_cnt_d   = 1'b0;
            state_d     = ST_FETCH1;
          end else begin
            out_d     = build_uop(dec, out_q.op1, out_q.op2, out_q.op3);
            uop_cnt_d = uop_cnt_q + 1'b1;
          end
        end
      end

      ST_TRAP: begin
        state_d = ST_TRAP;
      end

      default: begin
        state_d = ST_FETCH1;
      end
    endcase

    // Flush overrides every transition above. A handshake in this cycle still
    // counts as delivered; nothing further of the instruction is issued.
    if (flush) begin
      state_d     = ST_FETCH1;
      op1_d       = 8'h00;
      op2_d       = 8'h00;
      uop_cnt_d   = 1'b0;
      uop_valid_d = 1'b0;
      out_d       = UOP_OUT_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_FETCH1;
      op1_q       <= 8'h00;
      op2_q       <= 8'h00;
      uop_cnt_q   <= 1'b0;
      uop_valid_q <= 1'b0;
      out_q       <= UOP_OUT_IDLE;
    end else begin
      state_q     <= state_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      uop_cnt_q   <= uop_cnt_d;
      uop_valid_q <= uop_valid_d;
      out_q       <= out_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output mapping
  // ---------------------------------------------------------------------------
  assign uop_valid    = uop_valid_q;
  assign alu_op_code  = ALU_OP_W'(out_q.alu_op);
  assign src1_sel     = SEL_W'(out_q.src1);
  assign src2_sel     = SEL_W'(out_q.src2);
  assign dst_sel      = SEL_W'(out_q.dst);
  assign op1_out      = out_q.op1;
  assign op2_out      = out_q.op2;
  assign op3_out      = out_q.op3;
  assign uop_last     = out_q.last;
  // The stage is cleared when idle; the gate keeps pc_act quiet regardless.
  assign pc_act       = out_q.pc_act & {2{uop_valid_q}};
  assign illegal      = (state_q == ST_TRAP);
  assign decoder_wait = (state_q != ST_FETCH1);

endmodule
